// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / domain reset fabric.
// loss_cnt exists only when PLL_LOSS_COUNT_EN is defined.
interface pll_reset_sequencer_if #(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned MAX_RETRY   = 3
);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  logic                   pll_locked;
  logic                   soft_rst_req;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] dom_rst_n;
  logic                   ready;
  logic                   fail;
  logic [RW-1:0]          retry_cnt;
`ifdef PLL_LOSS_COUNT_EN
  logic [7:0]             loss_cnt;

  modport master (
    input  pll_locked, soft_rst_req,
    output pll_rst, dom_rst_n, ready, fail, retry_cnt, loss_cnt
  );
  modport slave (
    output pll_locked, soft_rst_req,
    input  pll_rst, dom_rst_n, ready, fail, retry_cnt, loss_cnt
  );
`else
  modport master (
    input  pll_locked, soft_rst_req,
    output pll_rst, dom_rst_n, ready, fail, retry_cnt
  );
  modport slave (
    output pll_locked, soft_rst_req,
    input  pll_rst, dom_rst_n, ready, fail, retry_cnt
  );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor with staged per-domain reset release and retry/fail handling.
// Optional lock-loss counter output enabled by defining PLL_LOSS_COUNT_EN.
module pll_reset_sequencer #(
  parameter int unsigned NUM_DOMAINS  = 4,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 32,
  parameter int unsigned STAGE_GAP    = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.master bus
);
  localparam int unsigned CMAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CMAX  = (CMAX0 > STAGE_GAP) ? CMAX0 : STAGE_GAP;
  localparam int unsigned CW    = $clog2(CMAX + 1);
  localparam int unsigned SW    = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RW    = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, SEQUENCE, RUN, FAIL} state_t;

  state_t                 state;
  logic                   sync1, lk_s;
  logic [CW-1:0]          cnt;
  logic [SW-1:0]          stab_cnt;
  logic [RW-1:0]          retry_q;
  logic                   pll_rst_q, ready_q, fail_q;
  logic [NUM_DOMAINS-1:0] dom_q, dom_next;
  logic                   abort;
`ifdef PLL_LOSS_COUNT_EN
  logic [7:0]             loss_q;
  assign bus.loss_cnt = loss_q;
`endif

  assign bus.pll_rst   = pll_rst_q;
  assign bus.dom_rst_n = dom_q;
  assign bus.ready     = ready_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;

  always_comb begin
    abort    = !lk_s || bus.soft_rst_req;
    dom_next = (dom_q << 1) | NUM_DOMAINS'(1);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lk_s  <= 1'b0;
    end else begin
      sync1 <= bus.pll_locked;
      lk_s  <= sync1;
    end
  end

  // Outputs are loaded on the same edge as the transition, so they reflect the new state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLL_RST;
      cnt       <= '0;
      stab_cnt  <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
`ifdef PLL_LOSS_COUNT_EN
      loss_q    <= '0;
`endif
    end else begin
      case (state)
        PLL_RST: begin
          if (bus.soft_rst_req) begin
            cnt <= '0;
          end else if (cnt == CW'(RST_CYCLES - 1)) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            stab_cnt  <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (bus.soft_rst_req) begin
            state     <= PLL_RST;
            cnt       <= '0;
            stab_cnt  <= '0;
            pll_rst_q <= 1'b1;
          end else if (lk_s && stab_cnt == SW'(LOCK_STABLE - 1)) begin
            stab_cnt <= stab_cnt + SW'(1);
            cnt      <= '0;
            dom_q    <= NUM_DOMAINS'(1);
            if (NUM_DOMAINS == 1) begin
              state   <= RUN;
              ready_q <= 1'b1;
              retry_q <= '0;
            end else begin
              state <= SEQUENCE;
            end
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            retry_q   <= retry_q + RW'(1);
            cnt       <= '0;
            stab_cnt  <= '0;
            pll_rst_q <= 1'b1;
            if (retry_q + RW'(1) == RW'(MAX_RETRY)) begin
              state  <= FAIL;
              fail_q <= 1'b1;
            end else begin
              state <= PLL_RST;
            end
          end else begin
            cnt      <= cnt + CW'(1);
            stab_cnt <= lk_s ? stab_cnt + SW'(1) : '0;
          end
        end
        SEQUENCE, RUN: begin
          if (abort) begin
            state     <= PLL_RST;
            cnt       <= '0;
            stab_cnt  <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
`ifdef PLL_LOSS_COUNT_EN
            if (!lk_s && loss_q != '1) loss_q <= loss_q + 8'd1;
`endif
          end else if (state == SEQUENCE) begin
            if (cnt == CW'(STAGE_GAP - 1)) begin
              cnt   <= '0;
              dom_q <= dom_next;
              if (&dom_next) begin
                state   <= RUN;
                ready_q <= 1'b1;
                retry_q <= '0;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        FAIL: begin
          pll_rst_q <= 1'b1;
          fail_q    <= 1'b1;
        end
        default: begin
          state     <= PLL_RST;
          cnt       <= '0;
          pll_rst_q <= 1'b1;
          dom_q     <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end
endmodule
